// File: rtl/order_engine_pkg.sv
// -----------------------------------------------------------------------------
// order_engine_pkg
// Shared definitions for the order decision engine: message field widths,
// message/side codes, the limit-table slot record and the price decision
// helper used by the decision stage.
// -----------------------------------------------------------------------------
package order_engine_pkg;

    localparam int unsigned TYPE_W  = 8;
    localparam int unsigned INST_W  = 24;
    localparam int unsigned PRICE_W = 32;
    localparam int unsigned DATA_W  = TYPE_W + INST_W + PRICE_W;

    localparam logic [TYPE_W-1:0] MSG_QUOTE = 8'h01;
    localparam logic [TYPE_W-1:0] SIDE_BUY  = 8'h10;
    localparam logic [TYPE_W-1:0] SIDE_SELL = 8'h11;

    typedef struct packed {
        logic               enable;
        logic [INST_W-1:0]  inst;
        logic [PRICE_W-1:0] buy_limit;
        logic [PRICE_W-1:0] sell_limit;
    } slot_t;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_BUY,
        DEC_SELL
    } decision_e;

    // Buy takes precedence when both limits are crossed; equality never trades.
    function automatic decision_e price_decision(
        input logic [PRICE_W-1:0] price,
        input logic [PRICE_W-1:0] buy_limit,
        input logic [PRICE_W-1:0] sell_limit
    );
        if (price < buy_limit) begin
            return DEC_BUY;
        end else if (price > sell_limit) begin
            return DEC_SELL;
        end
        return DEC_NONE;
    endfunction

endpackage

// File: rtl/order_decision_engine_if.sv
// -----------------------------------------------------------------------------
// order_decision_engine_if
// Quote input stream and order output stream of the order decision engine.
//   in_data/in_valid/in_ready    : quote stream into the engine
//   out_data/out_valid/out_ready : order stream out of the engine
// Modports: slave = engine side, master = feed/gateway side.
// -----------------------------------------------------------------------------
interface order_decision_engine_if;
    import order_engine_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/order_fifo.sv
// -----------------------------------------------------------------------------
// order_fifo
// First-word-fall-through FIFO: rdata shows the head whenever empty=0.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   push, wdata      : write request and data
//   pop              : remove head (ignored when empty)
//   rdata            : head entry, zero when empty
//   full, empty      : occupancy flags
//   count            : current occupancy
// A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/order_decision_engine.sv
// -----------------------------------------------------------------------------
// order_decision_engine
// Multi-instrument quote evaluator. Quotes are looked up in a programmable
// per-slot limit table; buy/sell candidate orders are queued in an output
// FIFO with credit-based backpressure on the quote input.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   bus (slave)       : quote stream in, order stream out
//   cfg_we/cfg_slot   : limit-table write strobe and target slot
//   cfg_inst          : instrument id for the slot
//   cfg_buy_limit     : buy when price < this
//   cfg_sell_limit    : sell when price > this
//   cfg_enable        : slot enable
//   order_count       : orders pushed into the FIFO (wraps)
// Pipeline: S1 register quote -> S2 register decision -> FIFO push.
// Optional feature macro: ORDER_ENGINE_COOLDOWN_EN (per-slot suppression
// window of COOLDOWN_CYC cycles after a slot emits an order).
// -----------------------------------------------------------------------------
module order_decision_engine
    import order_engine_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned COOLDOWN_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    order_decision_engine_if.slave        bus,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0]  cfg_slot,
    input  logic [INST_W-1:0]             cfg_inst,
    input  logic [PRICE_W-1:0]            cfg_buy_limit,
    input  logic [PRICE_W-1:0]            cfg_sell_limit,
    input  logic                          cfg_enable,
    output logic [31:0]                   order_count
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    if ((NUM_SLOTS < 2) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0)) begin : g_bad_slots
        $error("NUM_SLOTS must be a power of two >= 2");
    end
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 4");
    end
    if (COOLDOWN_CYC < 1) begin : g_bad_cooldown
        $error("COOLDOWN_CYC must be >= 1");
    end

    slot_t               table_q [NUM_SLOTS];

    logic                s1_valid_q;
    logic [TYPE_W-1:0]   s1_type_q;
    logic [INST_W-1:0]   s1_inst_q;
    logic [PRICE_W-1:0]  s1_price_q;

    logic                s2_valid_q;
    logic                s2_valid_d;
    logic [DATA_W-1:0]   s2_data_q;
    logic [DATA_W-1:0]   s2_data_d;

    logic [31:0]         order_count_q;

    logic                match_found;
    logic [SLOT_W-1:0]   match_idx;
    decision_e           dec;
    logic                cooling;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_rdata;
    logic [CNT_W:0]      credit_used;
    logic                accept;

    // Credits cover everything already committed downstream of the input so
    // the FIFO can never be asked to take an order it has no room for.
    assign credit_used  = {1'b0, fifo_count}
                        + (CNT_W+1)'(s1_valid_q)
                        + (CNT_W+1)'(s2_valid_q);
    assign bus.in_ready = !reset && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------------------------------------------------------- table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we) begin
            table_q[cfg_slot] <= '{enable:     cfg_enable,
                                   inst:       cfg_inst,
                                   buy_limit:  cfg_buy_limit,
                                   sell_limit: cfg_sell_limit};
        end
    end

    // ------------------------------------------------------------------- S1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_type_q  <= '0;
            s1_inst_q  <= '0;
            s1_price_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_type_q  <= bus.in_data[DATA_W-1 -: TYPE_W];
                s1_inst_q  <= bus.in_data[PRICE_W +: INST_W];
                s1_price_q <= bus.in_data[PRICE_W-1:0];
            end
        end
    end

    // Lowest-index enabled slot with a matching instrument wins.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!match_found && table_q[i].enable && (table_q[i].inst == s1_inst_q)) begin
                match_found = 1'b1;
                match_idx   = SLOT_W'(i);
            end
        end
    end

    // ------------------------------------------------------------- cooldown
`ifdef ORDER_ENGINE_COOLDOWN_EN
    localparam int unsigned CD_W = $clog2(COOLDOWN_CYC + 1);

    logic [CD_W-1:0] cool_q [NUM_SLOTS];

    assign cooling = (cool_q[match_idx] != '0);

    // A cfg write to a slot wins over a load in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                cool_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_we && (cfg_slot == SLOT_W'(i))) begin
                    cool_q[i] <= '0;
                end else if (s2_valid_d && (match_idx == SLOT_W'(i))) begin
                    cool_q[i] <= CD_W'(COOLDOWN_CYC);
                end else if (cool_q[i] != '0) begin
                    cool_q[i] <= cool_q[i] - CD_W'(1);
                end
            end
        end
    end
`else
    assign cooling = 1'b0;
`endif

    // ------------------------------------------------------------------- S2
    always_comb begin
        dec        = price_decision(s1_price_q,
                                    table_q[match_idx].buy_limit,
                                    table_q[match_idx].sell_limit);
        s2_valid_d = s1_valid_q
                  && (s1_type_q == MSG_QUOTE)
                  && match_found
                  && (dec != DEC_NONE)
                  && !cooling;
        s2_data_d  = {(dec == DEC_BUY) ? SIDE_BUY : SIDE_SELL, s1_inst_q, s1_price_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_valid_d) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

    // ----------------------------------------------------------------- FIFO
    assign fifo_pop = !fifo_empty && bus.out_ready;

    order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_valid_q),
        .wdata (s2_data_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_data  = fifo_rdata;
    assign bus.out_valid = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_count_q <= '0;
        end else if (s2_valid_q && (!fifo_full || fifo_pop)) begin
            order_count_q <= order_count_q + 32'd1;
        end
    end

    assign order_count = order_count_q;

endmodule
